// File: rtl/fft_buf_scheduler.sv
// Single-port FFT sample RAM scheduler: captures one frame of DEPTH samples,
// then lends the RAM port to the analysis reader until the buffer is released.
module fft_buf_scheduler #(
    parameter int unsigned DW     = 16,
    parameter int unsigned AW     = 12,
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          buf_release,
    input  logic          smp_valid,
    input  logic [DW-1:0] smp_data,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_gnt,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          buf_ready,
    output logic [7:0]    frame_cnt
);

    localparam int unsigned CW = AW + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_EXT = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_ANALYSE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_cnt_q, wr_cnt_d;
    logic            we_d;
    logic [AW-1:0]   addr_d;
    logic [DW-1:0]   wdata_d;
    logic [7:0]      frame_d;
    logic            addr_in_range;
    logic [RD_LAT:0] rd_pipe_q;

    // DEPTH may equal 2**AW, so compare with one extra bit of headroom
    assign addr_in_range = ({1'b0, rd_addr} < DEPTH_EXT);

    // Next-state and next-output logic; port owner is decided by state alone
    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        we_d     = 1'b0;
        addr_d   = ram_addr;
        wdata_d  = ram_wdata;
        frame_d  = frame_cnt;
        rd_gnt   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (smp_valid) begin
                    we_d    = 1'b1;
                    addr_d  = wr_cnt_q;
                    wdata_d = smp_data;
                    if (wr_cnt_q == LAST_ADDR) begin
                        wr_cnt_d = '0;
                        frame_d  = frame_cnt + 8'd1;
                        state_d  = S_ANALYSE;
                    end else begin
                        wr_cnt_d = wr_cnt_q + AW'(1);
                    end
                end
            end
            S_ANALYSE: begin
                // A request in the release cycle is still honoured
                rd_gnt = rd_req & addr_in_range;
                if (rd_gnt) begin
                    addr_d = rd_addr;
                end
                if (buf_release) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; the read pipeline drains across release
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_cnt_q  <= '0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            frame_cnt <= '0;
            busy      <= 1'b0;
            buf_ready <= 1'b0;
            rd_pipe_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            ram_we    <= we_d;
            ram_addr  <= addr_d;
            ram_wdata <= wdata_d;
            frame_cnt <= frame_d;
            busy      <= (state_d != S_IDLE);
            buf_ready <= (state_d == S_ANALYSE);
            rd_pipe_q <= {rd_pipe_q[RD_LAT-1:0], rd_gnt};
        end
    end

    assign rd_valid = rd_pipe_q[RD_LAT];
    assign rd_data  = ram_rdata;

endmodule
